// File: rtl/clock_divider_multi.sv
// clock_divider_multi: free-running divided_clocks bus plus NUM_CH programmable tick/square-wave channels
// configured through a two-state valid/ready port.
module clock_divider_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 24,
  parameter int FREE_W = 32,
  localparam int CH_W  = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  output logic [FREE_W-1:0] divided_clocks,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  input  logic [NUM_CH-1:0] en,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
);
  typedef enum logic {IDLE, APPLY} state_t;
  state_t             state_q, state_d;
  logic [CH_W-1:0]    lch;
  logic [CNT_W-1:0]   ldiv;
  logic               lmode;
  logic [CNT_W-1:0]   cnt [NUM_CH];
  logic [CNT_W-1:0]   div [NUM_CH];
  logic [NUM_CH-1:0]  mode;
  always_comb begin
    cfg_ready = state_q == IDLE;
    state_d   = state_q == APPLY ? IDLE : (cfg_valid ? APPLY : IDLE);
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      divided_clocks <= '0;
      lch            <= '0;
      ldiv           <= '0;
      lmode          <= 1'b0;
    end else begin
      state_q        <= state_d;
      divided_clocks <= divided_clocks + FREE_W'(1);
      if (cfg_valid && cfg_ready) begin
        lch   <= cfg_ch;
        ldiv  <= cfg_div;
        lmode <= cfg_mode;
      end
    end
  end
  // An out-of-range latched channel matches no index, so APPLY is a no-op for it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
        div[i] <= '0;
      end
      mode <= '0;
      tick <= '0;
      sq   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (state_q == APPLY && lch == CH_W'(i)) begin
          div[i]  <= ldiv;
          mode[i] <= lmode;
          cnt[i]  <= '0;
          tick[i] <= 1'b0;
          sq[i]   <= 1'b0;
        end else if (!en[i] || div[i] == '0) begin
          cnt[i]  <= '0;
          tick[i] <= 1'b0;
          sq[i]   <= 1'b0;
        end else if (cnt[i] == div[i]) begin
          cnt[i]  <= '0;
          tick[i] <= 1'b1;
          sq[i]   <= mode[i] ? ~sq[i] : 1'b0;
        end else begin
          cnt[i]  <= cnt[i] + CNT_W'(1);
          tick[i] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_clock_divider_multi.sv
// tb_clock_divider_multi: directed stimulus with a phase-arithmetic model checked every cycle,
// plus literal latency/count expectations.
module tb_clock_divider_multi;
  localparam int NC = 3, CW = 8, FW = 4;
  logic          clock = 1'b0, reset = 1'b0;
  logic [FW-1:0] divided_clocks;
  logic          cfg_valid = 1'b0, cfg_ready, cfg_mode = 1'b0;
  logic [1:0]    cfg_ch = '0;
  logic [CW-1:0] cfg_div = '0;
  logic [NC-1:0] en = '0, tick, sq;
  int n_cmp = 0, n_bad = 0;
  always #5 clock = ~clock;
  clock_divider_multi #(.NUM_CH(NC), .CNT_W(CW), .FREE_W(FW)) dut (
    .clock(clock), .reset(reset), .divided_clocks(divided_clocks),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_mode(cfg_mode), .en(en), .tick(tick), .sq(sq)
  );
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Model: a channel restarts at edge s; k edges later it ticks when k is a multiple of D+1
  // and its square wave is high during odd-numbered periods.
  int t = 0, m_free = 0, m_pend = 0, m_pch = 0, m_pdiv = 0, m_pmode = 0;
  int m_div[NC], m_mode[NC], m_start[NC];
  logic [NC-1:0] m_tick = '0, m_sq = '0;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      t = 0; m_free = 0; m_pend = 0;
      for (int i = 0; i < NC; i++) begin
        m_div[i] = 0; m_mode[i] = 0; m_start[i] = 0;
      end
      m_tick = '0; m_sq = '0;
    end else begin
      t++;
      m_free = (m_free + 1) % 16;
      for (int i = 0; i < NC; i++) begin
        if (m_pend == 1 && m_pch == i) begin
          m_div[i] = m_pdiv; m_mode[i] = m_pmode; m_start[i] = t;
          m_tick[i] = 1'b0; m_sq[i] = 1'b0;
        end else if (!en[i] || m_div[i] == 0) begin
          m_start[i] = t; m_tick[i] = 1'b0; m_sq[i] = 1'b0;
        end else begin
          m_tick[i] = ((t - m_start[i]) % (m_div[i] + 1)) == 0;
          m_sq[i]   = m_mode[i] == 1 && (((t - m_start[i]) / (m_div[i] + 1)) % 2) == 1;
        end
      end
      if (m_pend == 1) m_pend = 0;
      else if (cfg_valid) begin
        m_pend = 1; m_pch = int'(cfg_ch); m_pdiv = int'(cfg_div); m_pmode = int'(cfg_mode);
      end
    end
  end
  always @(negedge clock) begin
    if (reset) begin
      chk("tick", int'(tick), int'(m_tick));
      chk("sq", int'(sq), int'(m_sq));
      chk("divided_clocks", int'(divided_clocks), m_free);
      chk("cfg_ready", int'(cfg_ready), m_pend == 0 ? 1 : 0);
    end
  end
  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic do_cfg(input int ch, input int d, input int m);
    int k = 0;
    while (!cfg_ready && k < 10) begin step(1); k++; end
    cfg_ch = 2'(ch); cfg_div = CW'(d); cfg_mode = m[0]; cfg_valid = 1'b1;
    step(1);
    cfg_valid = 1'b0;
  endtask
  task automatic wait_tick(input int ch, output int k);
    k = 0;
    do begin step(1); k++; end while (!tick[ch] && k < 40);
  endtask
  task automatic window(input int ch, input int n, output int nt, output int ns);
    nt = 0; ns = 0;
    repeat (n) begin step(1); nt += int'(tick[ch]); ns += int'(sq[ch]); end
  endtask
  initial begin
    int k, nt, ns, acc, idx;
    int at[3];
    int bc[3] = '{0, 3, 1};
    int bd[3] = '{3, 5, 1};
    int bm[3] = '{1, 1, 0};
    step(2);
    reset = 1'b1;
    step(1);
    en = 3'b001;
    do_cfg(0, 3, 1);
    chk("ready_low_after_transfer", int'(cfg_ready), 0);
    step(1);
    chk("ready_back_after_apply", int'(cfg_ready), 1);
    wait_tick(0, k);
    chk("ch0_first_tick_latency", k, 4);
    window(0, 16, nt, ns);
    chk("ch0_ticks_in_16", nt, 4);
    chk("ch0_sq_high_in_16", ns, 8);
    en = 3'b111;
    do_cfg(1, 1, 0);
    do_cfg(2, 0, 1);
    step(2);
    window(1, 12, nt, ns);
    chk("ch1_ticks_in_12", nt, 6);
    chk("ch1_sq_mode0", ns, 0);
    window(2, 12, nt, ns);
    chk("ch2_d0_ticks", nt, 0);
    chk("ch2_d0_sq", ns, 0);
    k = 0;
    while (!cfg_ready && k < 10) begin step(1); k++; end
    acc = 0; idx = 0;
    cfg_ch = 2'(bc[0]); cfg_div = CW'(bd[0]); cfg_mode = bm[0][0]; cfg_valid = 1'b1;
    while (acc < 3 && idx < 20) begin
      if (cfg_ready) begin
        at[acc] = idx; acc++;
        step(1); idx++;
        if (acc < 3) begin
          cfg_ch = 2'(bc[acc]); cfg_div = CW'(bd[acc]); cfg_mode = bm[acc][0];
        end
      end else begin
        step(1); idx++;
      end
    end
    cfg_valid = 1'b0;
    chk("b2b_accepted", acc, 3);
    chk("b2b_second_at", at[1], 2);
    chk("b2b_third_at", at[2], 4);
    wait_tick(0, k);
    step(2);
    cfg_ch = 2'd0; cfg_div = CW'(9); cfg_mode = 1'b1; cfg_valid = 1'b1;
    step(1);
    cfg_valid = 1'b0;
    step(1);
    chk("apply_on_terminal_tick", int'(tick[0]), 0);
    chk("apply_on_terminal_sq", int'(sq[0]), 0);
    wait_tick(0, k);
    chk("ch0_d9_latency", k, 10);
    step(3);
    en[0] = 1'b0;
    step(1);
    chk("en_drop_tick", int'(tick[0]), 0);
    chk("en_drop_sq", int'(sq[0]), 0);
    step(2);
    en[0] = 1'b1;
    wait_tick(0, k);
    chk("reenable_latency", k, 10);
    k = 0;
    while (divided_clocks != 4'd15 && k < 20) begin step(1); k++; end
    chk("pre_wrap", int'(divided_clocks), 15);
    step(1);
    chk("wrap_to_zero", int'(divided_clocks), 0);
    do_cfg(1, 5, 1);
    step(8);
    cfg_ch = 2'd0; cfg_div = CW'(2); cfg_valid = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    cfg_valid = 1'b0;
    #1;
    chk("rst_tick", int'(tick), 0);
    chk("rst_sq", int'(sq), 0);
    chk("rst_divided_clocks", int'(divided_clocks), 0);
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    step(1);
    reset = 1'b1;
    step(3);
    chk("post_rst_count", int'(divided_clocks), 3);
    window(0, 10, nt, ns);
    chk("post_rst_ch0_idle", nt + ns, 0);
    window(1, 10, nt, ns);
    chk("post_rst_ch1_idle", nt + ns, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
